// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter plus FETCH/EXEC phase sequencer for the
// 4-bit CPU. Each instruction spends one cycle in FETCH and one in EXEC.
// The PC advances (or branches) only at the edge that closes EXEC.
// HALT is terminal until reset.
module pc_sequencer #(
    parameter int unsigned        WIDTH    = 4,
    parameter logic [WIDTH-1:0]   RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic [1:0]       phase,
    output logic             ir_load,
    output logic             exec_en,
    output logic             halted,
    output logic             wrapped
);

    // The encodings double as the externally visible phase code.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] PC_MAX = {WIDTH{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             wrapped_q;
    logic             wrapped_d;

    // Next-state, next-PC and wrap-pulse decode.
    // In EXEC, halt beats jump and jump beats increment.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wrapped_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else begin
                    if (jump) begin
                        // A branch to 0 is not a wrap, so wrapped stays low.
                        pc_d = jump_addr;
                    end else begin
                        pc_d      = pc_q + PC_ONE;
                        wrapped_d = (pc_q == PC_MAX);
                    end
                    if (run) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC and wrap-flag registers. Synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Outputs decode from registered state only.
    assign pc      = pc_q;
    assign phase   = state_q;
    assign ir_load = (state_q == ST_FETCH);
    assign exec_en = (state_q == ST_EXEC);
    assign halted  = (state_q == ST_HALT);
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Each cycle the full output bundle
// {phase, pc, ir_load, exec_en, halted, wrapped} is compared against a
// hand-computed expected vector.
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic       jump;
    logic [3:0] jump_addr;
    logic       halt;
    logic [3:0] pc;
    logic [1:0] phase;
    logic       ir_load;
    logic       exec_en;
    logic       halted;
    logic       wrapped;

    int n_cmp;
    int n_err;

    // Observed bundle: phase(2) pc(4) ir_load exec_en halted wrapped.
    logic [9:0] obs;
    logic [9:0] exp_v;
    assign obs = {phase, pc, ir_load, exec_en, halted, wrapped};

    pc_sequencer #(.WIDTH(4), .RESET_PC(4'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .jump      (jump),
        .jump_addr (jump_addr),
        .halt      (halt),
        .pc        (pc),
        .phase     (phase),
        .ir_load   (ir_load),
        .exec_en   (exec_en),
        .halted    (halted),
        .wrapped   (wrapped)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs settle 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; jump = 1'b1; jump_addr = 4'hA; halt = 1'b0;
        step();
        step();
        exp_v = {2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL reset_state got %b want %b", obs, exp_v); end
        // Release with run low: must stay idle.
        reset = 1'b0; run = 1'b0; jump = 1'b0;
        step();
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL idle_hold got %b want %b", obs, exp_v); end
    endtask

    task automatic test_straight_line();
        logic [1:0] e_ph;
        logic [3:0] e_pc;
        run = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            e_ph  = (i % 2 == 1) ? 2'b01 : 2'b10;
            e_pc  = 4'((i - 1) / 2);
            exp_v = {e_ph, e_pc, (e_ph == 2'b01), (e_ph == 2'b10), 1'b0, 1'b0};
            n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL straight_cycle%0d got %b want %b", i, obs, exp_v); end
            n_cmp++; if ((ir_load & exec_en) !== 1'b0) begin n_err++; $display("FAIL straight_overlap%0d got %b want 0", i, ir_load & exec_en); end
        end
    endtask

    // Entered in EXEC with pc=3.
    task automatic test_jump_wrap();
        jump = 1'b1; jump_addr = 4'hF;
        step();
        exp_v = {2'b01, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL jump_to_F got %b want %b", obs, exp_v); end
        jump = 1'b0;
        step();
        exp_v = {2'b10, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL exec_at_F got %b want %b", obs, exp_v); end
        step();
        exp_v = {2'b01, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL wrap_pulse got %b want %b", obs, exp_v); end
        step();
        exp_v = {2'b10, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL wrap_clears got %b want %b", obs, exp_v); end
        // Jump to 0 must not pulse wrapped.
        jump = 1'b1; jump_addr = 4'h0;
        step();
        exp_v = {2'b01, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL jump_to_0_nowrap got %b want %b", obs, exp_v); end
        jump = 1'b0;
        step();
        exp_v = {2'b10, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL exec_after_jump0 got %b want %b", obs, exp_v); end
    endtask

    // Entered in EXEC with pc=0.
    task automatic test_pause();
        jump = 1'b1; jump_addr = 4'h5;
        step();
        jump = 1'b0;
        step();
        exp_v = {2'b10, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL exec_at_5 got %b want %b", obs, exp_v); end
        run = 1'b0;
        step();
        exp_v = {2'b00, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL pause_to_idle got %b want %b", obs, exp_v); end
        for (int i = 0; i < 3; i++) begin
            // jump/halt must be ignored while idle.
            jump = i[0]; halt = i[1]; jump_addr = 4'hC;
            step();
            n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL pause_hold%0d got %b want %b", i, obs, exp_v); end
        end
        jump = 1'b0; halt = 1'b0; run = 1'b1;
        step();
        exp_v = {2'b01, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL resume_fetch got %b want %b", obs, exp_v); end
    endtask

    // Entered in FETCH with pc=6.
    task automatic test_halt_priority();
        // halt during FETCH is ignored.
        halt = 1'b1;
        step();
        halt = 1'b0; jump = 1'b1; jump_addr = 4'h9;
        exp_v = {2'b10, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL fetch_ignores_halt got %b want %b", obs, exp_v); end
        step();
        jump = 1'b0;
        step();
        exp_v = {2'b10, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL exec_at_9 got %b want %b", obs, exp_v); end
        halt = 1'b1; jump = 1'b1; jump_addr = 4'h2;
        step();
        exp_v = {2'b11, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL halt_beats_jump got %b want %b", obs, exp_v); end
        for (int i = 0; i < 4; i++) begin
            run = i[0]; jump = ~i[0]; halt = i[1]; jump_addr = 4'(i + 1);
            step();
            n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL halt_sticky%0d got %b want %b", i, obs, exp_v); end
        end
    endtask

    // Entered in HALT with pc=9.
    task automatic test_reset_mid();
        reset = 1'b1; run = 1'b1; jump = 1'b0; halt = 1'b0;
        step();
        exp_v = {2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL reset_from_halt got %b want %b", obs, exp_v); end
        reset = 1'b0;
        step();
        exp_v = {2'b01, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL restart_after_halt got %b want %b", obs, exp_v); end
        step();
        jump = 1'b1; jump_addr = 4'h7;
        step();
        jump = 1'b0;
        exp_v = {2'b01, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL fetch_at_7 got %b want %b", obs, exp_v); end
        reset = 1'b1;
        step();
        exp_v = {2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL reset_from_fetch got %b want %b", obs, exp_v); end
        reset = 1'b0;
        step();
        exp_v = {2'b01, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL restart_after_fetch got %b want %b", obs, exp_v); end
    endtask

    // Scenario sequence; each task leaves the DUT in the state the next expects.
    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; run = 1'b0; jump = 1'b0; jump_addr = 4'h0; halt = 1'b0;
        #1;
        test_reset();
        test_straight_line();
        test_jump_wrap();
        test_pause();
        test_halt_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
